// File: rtl/restoring_divider_seq.sv
// Sequential restoring divider: one quotient bit per clock via shift-and-subtract,
// start/busy/done handshake. Define DIVIDER_SIGNED_EN for two's-complement operands.
module restoring_divider_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic             r_busy;
  logic             r_done;
  logic             r_dbz;

  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH:0]   w_rsh;
  logic [WIDTH:0]   w_t;
  logic [WIDTH-1:0] w_q_next;
  logic [WIDTH-1:0] w_r_next;
  logic [WIDTH-1:0] w_q_fin;
  logic [WIDTH-1:0] w_r_fin;

`ifdef DIVIDER_SIGNED_EN
  logic r_neg_q;
  logic r_neg_r;

  // Most-negative magnitude wraps to itself, which is correct as an unsigned value.
  assign w_a_mag = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
  assign w_b_mag = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;
  assign w_q_fin = r_neg_q ? (~w_q_next + 1'b1) : w_q_next;
  assign w_r_fin = r_neg_r ? (~w_r_next + 1'b1) : w_r_next;
`else
  assign w_a_mag = dividend;
  assign w_b_mag = divisor;
  assign w_q_fin = w_q_next;
  assign w_r_fin = w_r_next;
`endif

  // Partial remainder always stays below the divisor, so WIDTH bits hold it between steps.
  assign w_rsh    = {r_r, r_q[WIDTH-1]};
  assign w_t      = w_rsh + {1'b1, ~r_div} + {{WIDTH{1'b0}}, 1'b1};
  assign w_q_next = {r_q[WIDTH-2:0], ~w_t[WIDTH]};
  assign w_r_next = w_t[WIDTH] ? w_rsh[WIDTH-1:0] : w_t[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_q     <= '0;
      r_r     <= '0;
      r_div   <= '0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            if (divisor == '0) begin
              // Result loads now; done rises on the following edge.
              r_state <= S_DONE;
              r_quot  <= '1;
              r_rem   <= dividend;
              r_dbz   <= 1'b1;
            end else begin
              r_state <= S_RUN;
              r_q     <= w_a_mag;
              r_r     <= '0;
              r_div   <= w_b_mag;
              r_cnt   <= CNT_W'(WIDTH);
              r_busy  <= 1'b1;
              r_dbz   <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
              r_neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
              r_neg_r <= dividend[WIDTH-1];
`endif
            end
          end
        end
        S_RUN: begin
          r_q   <= w_q_next;
          r_r   <= w_r_next;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CNT_W'(1)) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_quot  <= w_q_fin;
            r_rem   <= w_r_fin;
          end
        end
        S_DONE: begin
          if (r_done) begin
            r_done  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign quotient    = r_quot;
  assign remainder   = r_rem;
  assign busy        = r_busy;
  assign done        = r_done;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_restoring_divider_seq.sv
// Self-checking bench for restoring_divider_seq (WIDTH=4): vector table, corner
// sequences and a shuffled sweep of all operand pairs against an arithmetic model.
module tb_restoring_divider_seq;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_by_zero;

  int total = 0;
  int bad = 0;

  restoring_divider_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder), .busy(busy), .done(done),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           lat;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: plain integer division on the operand values.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic dz, output int lat);
    int sa, sb;
`ifdef DIVIDER_SIGNED_EN
    sa = int'($signed(a));
    sb = int'($signed(b));
`else
    sa = int'(a);
    sb = int'(b);
`endif
    if (sb == 0) begin
      q = '1; r = a; dz = 1'b1; lat = 2;
    end else begin
      q = W'(sa / sb); r = W'(sa % sb); dz = 1'b0; lat = W + 1;
    end
  endfunction

  // Wait for done, counting edges; edges already holds the count so far.
  task automatic wait_done(inout int edges);
    while (!done && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic run_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er,
                         input logic edz, input int elat);
    int edges;
    @(negedge clk);
    dividend = a; divisor = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    edges = 1;
    if (b != '0) check({tag, " busy"}, int'(busy), 1);
    wait_done(edges);
    check({tag, " latency"}, edges, elat);
    check({tag, " q"}, int'(quotient), int'(eq));
    check({tag, " r"}, int'(remainder), int'(er));
    check({tag, " dz"}, int'(div_by_zero), int'(edz));
    @(posedge clk); #1;
    check({tag, " done width"}, int'(done), 0);
  endtask

  initial begin
    vec_t vecs[$];
    logic [W-1:0] mq, mr;
    logic mdz;
    int mlat, edges, seen, off;

`ifdef DIVIDER_SIGNED_EN
    vecs.push_back('{4'b1001, 4'd2,    4'b1101, 4'b1111, 1'b0, 5});
    vecs.push_back('{4'd7,    4'b1110, 4'b1101, 4'd1,    1'b0, 5});
    vecs.push_back('{4'b1000, 4'b1111, 4'b1000, 4'd0,    1'b0, 5});
    vecs.push_back('{4'd7,    4'd0,    4'hF,    4'd7,    1'b1, 2});
    vecs.push_back('{4'd6,    4'd3,    4'd2,    4'd0,    1'b0, 5});
`else
    vecs.push_back('{4'd13, 4'd3, 4'd4,  4'd1, 1'b0, 5});
    vecs.push_back('{4'd15, 4'd1, 4'd15, 4'd0, 1'b0, 5});
    vecs.push_back('{4'd3,  4'd5, 4'd0,  4'd3, 1'b0, 5});
    vecs.push_back('{4'd0,  4'd7, 4'd0,  4'd0, 1'b0, 5});
    vecs.push_back('{4'd7,  4'd0, 4'hF,  4'd7, 1'b1, 2});
    vecs.push_back('{4'd9,  4'd3, 4'd3,  4'd0, 1'b0, 5});
`endif

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset q", int'(quotient), 0);
    check("reset r", int'(remainder), 0);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset dz", int'(div_by_zero), 0);

    foreach (vecs[i])
      run_div($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r,
              vecs[i].dz, vecs[i].lat);

    // start pulsed during RUN must be ignored
    model(4'd13, 4'd3, mq, mr, mdz, mlat);
    @(negedge clk);
    dividend = 4'd13; divisor = 4'd3; start = 1'b1;
    @(posedge clk); #1;
    edges = 1;
    dividend = 4'd2; divisor = 4'd1;
    @(posedge clk); #1;
    start = 1'b0;
    edges++;
    wait_done(edges);
    check("ign latency", edges, mlat);
    check("ign q", int'(quotient), int'(mq));
    check("ign r", int'(remainder), int'(mr));

    // reset in the second RUN cycle aborts with no done
    @(negedge clk);
    dividend = 4'd5; divisor = 4'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("hold q while busy", int'(quotient), int'(mq));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort q", int'(quotient), 0);
    check("abort r", int'(remainder), 0);
    check("abort busy", int'(busy), 0);
    check("abort done", int'(done), 0);
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    check("abort no done", seen, 0);

    // every operand pair, visited in a shuffled order
    off = int'($urandom_range(0, 255));
    for (int i = 0; i < 256; i++) begin
      int idx;
      logic [W-1:0] a, b;
      idx = (i * 167 + off) % 256;
      a = W'(idx / 16);
      b = W'(idx % 16);
      model(a, b, mq, mr, mdz, mlat);
      run_div($sformatf("sweep %0d/%0d", a, b), a, b, mq, mr, mdz, mlat);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
